// File: rtl/alu_iter_if.sv
// Operation/result handshake bundle for alu_iter.
// The producer/consumer side uses master and the ALU uses slave.
interface alu_iter_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      alu_op;
  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] alu_src2;
  logic             overflow_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] alu_result_hi;
  logic             overflow;

  modport master (
    output flush, in_valid, alu_op, alu_src1, alu_src2, overflow_en, out_ready,
    input  in_ready, out_valid, alu_result, alu_result_hi, overflow
  );

  modport slave (
    input  flush, in_valid, alu_op, alu_src1, alu_src2, overflow_en, out_ready,
    output in_ready, out_valid, alu_result, alu_result_hi, overflow
  );
endinterface

// File: rtl/alu_iter.sv
// Single-cycle ALU plus iterative (one bit per cycle) multiplier and optional divider.
// Define ALU_ITER_DIV_EN to build the div/divu datapath; otherwise ops 14/15 return 0.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  alu_iter_if.slave bus
);
  localparam int SH = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [SH-1:0]    cnt;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;
  logic             mul_neg;
`ifdef ALU_ITER_DIV_EN
  logic             is_div;
  logic             q_neg;
  logic             r_neg;
`endif
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_hi_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.alu_result    = res_q;
  assign bus.alu_result_hi = res_hi_q;
  assign bus.overflow      = ovf_q;

  logic [15:0]      op;
  logic [WIDTH-1:0] a, b;
  logic [SH-1:0]    shamt;
  assign op    = bus.alu_op;
  assign a     = bus.alu_src1;
  assign b     = bus.alu_src2;
  assign shamt = a[SH-1:0];

  // ---------------- single-cycle ops ----------------
  logic [WIDTH-1:0] sum, dif, sc_res;
  logic             add_ovf, sub_ovf, sc_ovf;

  assign sum     = a + b;
  assign dif     = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) & (dif[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    if (op[0]) begin
      sc_res = sum;
      sc_ovf = bus.overflow_en & add_ovf;
    end else if (op[1]) begin
      sc_res = dif;
      sc_ovf = bus.overflow_en & sub_ovf;
    end
    else if (op[2])  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
    else if (op[3])  sc_res = {{(WIDTH-1){1'b0}}, a < b};
    else if (op[4])  sc_res = a & b;
    else if (op[5])  sc_res = ~(a | b);
    else if (op[6])  sc_res = a | b;
    else if (op[7])  sc_res = a ^ b;
    else if (op[8])  sc_res = b << shamt;
    else if (op[9])  sc_res = b >> shamt;
    else if (op[10]) sc_res = $signed(b) >>> shamt;
    else if (op[11]) sc_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
    // div/divu in a divider-less build land here too and yield 0
    else if (op[14] | op[15]) sc_res = '0;
  end

  // ---------------- multi-cycle operand prep ----------------
  // Signed ops iterate on magnitudes and fix the sign after the last step.
  logic             is_signed, neg_a, neg_b, is_mul, is_dv, multi;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_signed = op[12] | op[14];
  assign neg_a     = is_signed & a[WIDTH-1];
  assign neg_b     = is_signed & b[WIDTH-1];
  assign mag_a     = neg_a ? -a : a;
  assign mag_b     = neg_b ? -b : b;
  assign is_mul    = op[12] | op[13];
`ifdef ALU_ITER_DIV_EN
  assign is_dv     = op[14] | op[15];
`else
  assign is_dv     = 1'b0;
`endif
  assign multi     = is_mul | is_dv;

  // ---------------- iteration step ----------------
  logic [WIDTH:0]     mul_sum, hi_nxt;
  logic [WIDTH-1:0]   lo_nxt, fin_lo, fin_hi;
  logic [2*WIDTH-1:0] prod, prod_fix;
`ifdef ALU_ITER_DIV_EN
  logic [WIDTH:0]     rem_sh, rem_dif;
`endif

  always_comb begin
    // shift-add multiply: acc_hi collects partial sums, acc_lo holds the multiplier
    mul_sum = acc_hi + (acc_lo[0] ? {1'b0, opb} : '0);
    hi_nxt  = {1'b0, mul_sum[WIDTH:1]};
    lo_nxt  = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef ALU_ITER_DIV_EN
    // restoring divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
    rem_sh  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    rem_dif = rem_sh - {1'b0, opb};
    if (is_div) begin
      if (!rem_dif[WIDTH]) begin
        hi_nxt = rem_dif;
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = rem_sh;
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
    prod     = {hi_nxt[WIDTH-1:0], lo_nxt};
    prod_fix = mul_neg ? -prod : prod;
    fin_lo   = prod_fix[WIDTH-1:0];
    fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
`ifdef ALU_ITER_DIV_EN
    if (is_div) begin
      fin_lo = q_neg ? -lo_nxt : lo_nxt;
      fin_hi = r_neg ? -hi_nxt[WIDTH-1:0] : hi_nxt[WIDTH-1:0];
    end
`endif
  end

  // ---------------- FSM and datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      res_hi_q    <= '0;
      ovf_q       <= 1'b0;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opb         <= '0;
      mul_neg     <= 1'b0;
`ifdef ALU_ITER_DIV_EN
      is_div      <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else if (bus.flush) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          in_ready_q <= 1'b0;
          if (multi) begin
            state   <= BUSY;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= is_mul ? mag_b : mag_a;
            opb     <= is_mul ? mag_a : mag_b;
            mul_neg <= is_mul & (neg_a ^ neg_b);
`ifdef ALU_ITER_DIV_EN
            is_div  <= is_dv;
            // a zero divisor keeps the all-ones quotient un-negated
            q_neg   <= is_dv & (neg_a ^ neg_b) & (b != '0);
            r_neg   <= is_dv & neg_a;
`endif
          end else begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            res_q       <= sc_res;
            res_hi_q    <= '0;
            ovf_q       <= sc_ovf;
          end
        end
        BUSY: begin
          acc_hi <= hi_nxt;
          acc_lo <= lo_nxt;
          cnt    <= cnt + SH'(1);
          if (cnt == SH'(WIDTH-1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            res_q       <= fin_lo;
            res_hi_q    <= fin_hi;
            ovf_q       <= 1'b0;
          end
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_iter.sv
// Randomized bench for alu_iter (WIDTH=32) against an arithmetic reference model.
// Honours ALU_ITER_DIV_EN the same way the design does.
module tb_alu_iter;
  localparam int W = 32;
`ifdef ALU_ITER_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -SMAX - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_iter_if #(.WIDTH(W)) bus ();
  alu_iter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  bit          pending = 1'b0;
  logic [31:0] exp_r, exp_h;
  bit          exp_ov;
  int          exp_lat;
  logic [31:0] last_r, last_h;
  bit          last_ov;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: results from plain 64-bit arithmetic; op 16 means all-zero opcode.
  function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                input bit oen, output logic [31:0] r, output logic [31:0] rh,
                                output bit ov, output int lat);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          s;
    longint unsigned u;
    r = '0; rh = '0; ov = 1'b0; lat = 1;
    case (op)
      0:  begin s = sa + sb; r = 32'(s); ov = oen && (s > SMAX || s < SMIN); end
      1:  begin s = sa - sb; r = 32'(s); ov = oen && (s > SMAX || s < SMIN); end
      2:  r = {31'b0, sa < sb};
      3:  r = {31'b0, ua < ub};
      4:  r = a & b;
      5:  r = ~(a | b);
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = b << a[4:0];
      9:  r = b >> a[4:0];
      10: r = 32'(sb >>> a[4:0]);
      11: r = {b[15:0], 16'h0};
      12: begin s = sa * sb; r = s[31:0]; rh = s[63:32]; lat = 33; end
      13: begin u = ua * ub; r = u[31:0]; rh = u[63:32]; lat = 33; end
      14: if (DIV_EN) begin
            lat = 33;
            if (b == 0) begin r = '1; rh = a; end
            else begin r = 32'(sa / sb); rh = 32'(sa % sb); end
          end
      15: if (DIV_EN) begin
            lat = 33;
            if (b == 0) begin r = '1; rh = a; end
            else begin r = 32'(ua / ub); rh = 32'(ua % ub); end
          end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && !pending)
        check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
      else if (bus.out_valid) begin
        check("alu_result", 64'(bus.alu_result), 64'(exp_r));
        check("alu_result_hi", 64'(bus.alu_result_hi), 64'(exp_h));
        check("overflow", 64'(bus.overflow), 64'(exp_ov));
        check("in_ready_done", 64'(bus.in_ready), 64'd0);
      end else if (pending)
        check("in_ready_busy", 64'(bus.in_ready), 64'd0);
    end
  end

  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input bit oen,
                        input int hold, input bit lit, input logic [31:0] lr,
                        input logic [31:0] lh, input bit lov);
    int w;
    int lat;
    w = 0;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
      return;
    end
    bus.in_valid    = 1'b1;
    bus.alu_op      = (op > 15) ? 16'h0 : (16'h1 << op);
    bus.alu_src1    = a;
    bus.alu_src2    = b;
    bus.overflow_en = oen;
    model(op, a, b, oen, exp_r, exp_h, exp_ov, exp_lat);
    @(posedge clk);
    pending = 1'b1;
    #1;
    // scramble inputs after accept; they must be ignored
    bus.in_valid    = 1'b0;
    bus.alu_op      = 16'h1 << $urandom_range(0, 15);
    bus.alu_src1    = $urandom;
    bus.alu_src2    = $urandom;
    bus.overflow_en = 1'($urandom);
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
    check("latency", 64'(lat), 64'(exp_lat));
    if (lit) begin
      check("lit_result", 64'(bus.alu_result), 64'(lr));
      check("lit_result_hi", 64'(bus.alu_result_hi), 64'(lh));
      check("lit_overflow", 64'(bus.overflow), 64'(lov));
    end
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    pending = 1'b0;
    last_r = exp_r; last_h = exp_h; last_ov = exp_ov;
    @(negedge clk);
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic start_mul();
    bus.in_valid = 1'b1; bus.alu_op = 16'h1 << 12;
    bus.alu_src1 = 32'h3; bus.alu_src2 = 32'h4; bus.overflow_en = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.alu_op = '0;
    bus.alu_src1 = '0; bus.alu_src2 = '0; bus.overflow_en = 1'b0; bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.alu_result), 64'd0);
    check("rst_result_hi", 64'(bus.alu_result_hi), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);

    // hand-computed vectors
    run_op(0, 32'h7FFF_FFFF, 32'h1, 1'b1, 0, 1'b1, 32'h8000_0000, 32'h0, 1'b1);
    run_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 0, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
    run_op(12, 32'hFFFF_FFFD, 32'h5, 1'b0, 0, 1'b1, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0);
    run_op(13, 32'hFFFF_FFFD, 32'h5, 1'b0, 0, 1'b1, 32'hFFFF_FFF1, 32'h4, 1'b0);
    if (DIV_EN) begin
      run_op(14, 32'h7, 32'hFFFF_FFFE, 1'b0, 0, 1'b1, 32'hFFFF_FFFD, 32'h1, 1'b0);
      run_op(15, 32'h1234, 32'h0, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b0);
      run_op(14, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
    end else begin
      run_op(15, 32'd10, 32'd3, 1'b0, 0, 1'b1, 32'h0, 32'h0, 1'b0);
    end
    run_op(10, 32'd4, 32'h8000_0000, 1'b0, 5, 1'b1, 32'hF800_0000, 32'h0, 1'b0);
    run_op(8, 32'd31, 32'h1, 1'b0, 0, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
    run_op(9, 32'd31, 32'h8000_0000, 1'b0, 0, 1'b1, 32'h1, 32'h0, 1'b0);
    run_op(11, 32'h0, 32'h1234_ABCD, 1'b0, 0, 1'b1, 32'hABCD_0000, 32'h0, 1'b0);
    run_op(16, 32'h5, 32'h6, 1'b1, 0, 1'b1, 32'h0, 32'h0, 1'b0);

    // reset in the middle of a multiply
    start_mul();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    last_r = '0; last_h = '0; last_ov = 1'b0;
    @(negedge clk);
    check("busy_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("busy_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("busy_rst_result", 64'(bus.alu_result), 64'd0);
    check("busy_rst_result_hi", 64'(bus.alu_result_hi), 64'd0);
    run_op(0, 32'd2, 32'd3, 1'b0, 0, 1'b1, 32'd5, 32'h0, 1'b0);

    // flush in the middle of a multiply keeps the previous outputs
    start_mul();
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_result", 64'(bus.alu_result), 64'(last_r));
    check("flush_result_hi", 64'(bus.alu_result_hi), 64'(last_h));
    check("flush_overflow", 64'(bus.overflow), 64'(last_ov));

    // flush together with in_valid must not accept
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.alu_op = 16'h1;
    bus.alu_src1 = 32'd9; bus.alu_src2 = 32'd9;
    @(posedge clk);
    #1 begin bus.flush = 1'b0; bus.in_valid = 1'b0; end
    @(negedge clk);
    check("flush_noacc_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("flush_noacc_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_noacc_result", 64'(bus.alu_result), 64'(last_r));

    // randomized operations
    for (int i = 0; i < 200; i++)
      run_op($urandom_range(0, 16), pick(), pick(), 1'($urandom), $urandom_range(0, 2),
             1'b0, 32'h0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; power of two, 8..64; SH = log2(WIDTH).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 flush  input  1  abort any operation in flight.
REQ-006 in_valid  input  1  operands/op presented.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 alu_op  input  16  one-hot opcode: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui, 12 mul, 13 mulu, 14 div, 15 divu.
REQ-009 alu_src1  input  WIDTH  operand 1, dividend, or shift amount in bits [SH-1:0].
REQ-010 alu_src2  input  WIDTH  operand 2, divisor, or shifted value.
REQ-011 overflow_en  input  1  enable signed overflow reporting for add/sub.
REQ-012 out_valid  output  1  result registered and held.
REQ-013 out_ready  input  1  consumer takes result.
REQ-014 alu_result  output  WIDTH  primary result: low product, quotient, or single-cycle result.
REQ-015 alu_result_hi  output  WIDTH  high product or remainder; 0 for all other ops.
REQ-016 overflow  output  1  signed add/sub overflow, gated by overflow_en.

Function
REQ-017 FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE).
REQ-018 Accept on in_valid & in_ready; alu_op, operands, and overflow_en are captured at accept, and later input changes are ignored.
REQ-019 Ops 0-11 from IDLE: go to DONE next cycle; out_valid rises 1 cycle after accept.
REQ-020 Ops 12-15 from IDLE: go to BUSY for exactly WIDTH cycles (iterative, one bit per cycle), then DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-021 DONE: out_valid=1; alu_result, alu_result_hi, and overflow are held stable until out_valid & out_ready; the FSM then returns to IDLE on the next cycle.
REQ-022 add/sub: modulo 2^WIDTH; overflow = overflow_en & signed overflow of the actual operation; overflow=0 for all other ops.
REQ-023 slt/sltu: signed/unsigned src1<src2 gives 1, else 0, zero-extended.
REQ-024 sll/srl/sra: shift src2 by src1[SH-1:0]; sra fills with src2[WIDTH-1]; a shift of 0 returns src2.
REQ-025 lui: {src2[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-026 mul/mulu: full 2*WIDTH signed/unsigned product; high half goes to alu_result_hi.
REQ-027 div/divu: quotient truncated toward zero; remainder takes the sign of the dividend.
REQ-028 Divisor 0: quotient all ones, remainder = dividend (signed and unsigned).
REQ-029 Signed MIN / -1: quotient = MIN, remainder 0; no overflow flag.
REQ-030 alu_op all-zero: treated as a single-cycle op, result 0. Multi-hot alu_op is illegal and unverified.
REQ-031 flush in any state: next cycle IDLE, out_valid=0, output registers unchanged. A flush coinciding with in_valid does not accept.

Reset
REQ-032 reset has priority over flush and the handshakes.
REQ-033 Next cycle after reset: state IDLE, in_ready=1, out_valid=0, alu_result=0, alu_result_hi=0, overflow=0, iteration counter=0.
REQ-034 reset during BUSY discards the partial result; the first op after reset behaves identically to one issued after power-up.

Configuration
REQ-035 Macro ALU_ITER_DIV_EN.
REQ-036 Defined: div/divu are implemented per REQ-020/027-029.
REQ-037 Undefined: no divider hardware; ops 14/15 complete as single-cycle ops with alu_result=0, alu_result_hi=0, overflow=0. mul/mulu are unaffected.

Verification (WIDTH=32)
REQ-038 add 0x7FFFFFFF+0x1, overflow_en=1 -> out_valid 1 cycle after accept, alu_result 0x80000000, overflow=1; the same op with overflow_en=0 gives overflow=0.
REQ-039 mul 0xFFFFFFFD*0x5 -> out_valid exactly 33 cycles after accept, alu_result 0xFFFFFFF1, alu_result_hi 0xFFFFFFFF; mulu of the same operands gives alu_result_hi 0x4.
REQ-040 div 7/0xFFFFFFFE -> alu_result 0xFFFFFFFD, alu_result_hi 0x1; divu 0x1234/0 -> alu_result 0xFFFFFFFF, alu_result_hi 0x1234; div 0x80000000/0xFFFFFFFF -> alu_result 0x80000000, alu_result_hi 0.
REQ-041 sra 0x80000000 by 4 -> 0xF8000000; sll 0x1 by 31 -> 0x80000000; srl 0x80000000 by 31 -> 0x1; hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-042 reset asserted at BUSY cycle 10 of a mul -> next cycle in_ready=1, out_valid=0, outputs 0; a following add 2+3 returns 5 after 1 cycle. Repeat with flush: outputs keep their prior values.
REQ-043 Build without ALU_ITER_DIV_EN: divu 10/3 -> out_valid after 1 cycle with alu_result 0 and alu_result_hi 0.
